seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Multiplexed 4-digit seven-segment display driver.
- Sits directly downstream of the 1 kHz single-cycle tick generator and consumes its tick as a clock enable.
- Snapshots a packed hex value once per frame and scans the digits one at a time, with a blanking gap between digits to suppress ghosting.
- Also supports optional leading-zero suppression and per-digit decimal points.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- DWELL_TICKS, 4, ticks each digit is lit; must be 1 or more.
- BLANK_TICKS, 1, ticks all anodes are off between digits; 0 disables the blank phase.

Ports:
- in_clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  scan enable, one in_clk cycle wide (the 1 kHz tick); every high cycle counts as one tick.
- en  input  1  display enable; low forces the display dark.
- value  input  4*NUM_DIGITS  hex digits; bits [3:0] are digit 0 (rightmost).
- dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high.
- lz_en  input  1  leading-zero suppression enable.
- an  output  NUM_DIGITS  anode selects, active-low, one-hot-low when lit.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal-point cathode, active-low.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - an = all 1s, seg = 7'h7F, dp = 1.
  - State = IDLE, digit index = 0, tick counter = 0, snapshot = 0.
- All outputs are registered. A change caused by a tick appears on the in_clk edge after the tick is sampled (latency 1 cycle). No output changes on cycles without a tick, except for the en-low case.
- FSM states: IDLE, SHOW, BLANK.
- IDLE:
  - Outputs dark.
  - On tick with en=1: snapshot value, dp_in and lz_en; go to SHOW with idx=0 and counter=0.
- SHOW:
  - an[idx]=0, all other anodes 1.
  - seg = hex pattern of snapshot digit idx, or 7'h7F if that digit is suppressed.
  - dp = ~dp_snap[idx].
  - Each tick increments the counter. On the tick where counter reaches DWELL_TICKS-1:
    - If BLANK_TICKS>0: go to BLANK with counter=0, outputs dark.
    - Otherwise: advance idx directly and stay in SHOW.
- BLANK:
  - Outputs dark.
  - On the tick where counter reaches BLANK_TICKS-1: advance idx and go to SHOW.
- Advancing idx:
  - idx = idx+1, wrapping from NUM_DIGITS-1 to 0.
  - On every wrap to 0, take a new snapshot of value, dp_in and lz_en (frame-coherent; no tearing mid-frame).
- Leading-zero suppression, when lz_snap=1:
  - Digit k is suppressed if digits NUM_DIGITS-1 down to k are all zero.
  - Digit 0 is never suppressed.
  - dp of a suppressed digit is still honoured.
- Segment patterns: standard hex 0-F, active-low.
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- en deasserted in any state:
  - Next in_clk edge goes to IDLE with outputs dark, regardless of tick.
  - Re-enable restarts at digit 0 with a fresh snapshot on the next tick.
- Reset mid-scan: outputs go dark immediately (asynchronous). Scanning resumes from IDLE.
- A tick held high for N cycles counts as N ticks; no edge detection is performed.
- Counter width is clog2(max(DWELL_TICKS, BLANK_TICKS)), minimum 1 bit. idx width is clog2(NUM_DIGITS).
- Frame period = NUM_DIGITS*(DWELL_TICKS+BLANK_TICKS) ticks; 20 ms at defaults.

Decomposition:
- Shared package seg7_pkg:
  - Hex-to-segment pattern constants.
  - SEG_OFF = 7'h7F.
  - State encoding for IDLE/SHOW/BLANK.
- One sub-module: hex_to_7seg, purely combinational, 4-bit in and 7-bit active-low out; instantiated once on the selected digit.
- seg7_scan holds the FSM, counters, snapshot registers and suppression logic.

Test Plan:
- Reset then en=1, value=16'h1234, DWELL=2, BLANK=1, ticks every 10 cycles:
  - One cycle after tick 1: an=4'b1110, seg=7'h19.
  - After tick 3: an=4'hF.
  - After tick 4: an=4'b1101, seg=7'h30.
  - Scan continues through digits 2 and 3, then wraps to digit 0.
- value=16'h0070, lz_en=1:
  - Digit 3 and digit 2 are dark.
  - Digit 1 shows 7'h78; digit 0 shows 7'h40.
  - With lz_en=0, digit 3 and digit 2 show 7'h40.
- value changed from 16'h1111 to 16'h2222 while digit 1 is lit:
  - Digits 1-3 still show 7'h79 for the rest of the frame.
  - Digit 0 of the next frame shows 7'h24.
- dp_in=4'b0100, value=0, lz_en=1: dp=0 only while an=4'b1011, with seg=7'h7F for that digit.
- en dropped mid-SHOW with no tick: next edge gives an=4'hF, seg=7'h7F, dp=1. Re-enable followed by a tick gives an=4'b1110.
- rst_n pulsed low between clock edges during SHOW: outputs go dark without waiting for a clock edge. After release, no digit is lit until the first tick.

Source files
------------

// File: rtl/seg7_pkg.sv
//==============================================================================
// seg7_pkg - shared seven-segment patterns and scan FSM encoding. Rev 1.0
//==============================================================================
`default_nettype none

package seg7_pkg;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

endpackage

`default_nettype wire

// File: rtl/hex_to_7seg.sv
//==============================================================================
// hex_to_7seg - combinational hex nibble to active-low segment decoder. Rev 1.0
//==============================================================================
`default_nettype none

module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan.sv
//==============================================================================
// seg7_scan - tick-driven multiplexed seven-segment scanner with blanking gap. Rev 1.0
//==============================================================================
`default_nettype none

module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                    in_clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int c_max_ticks = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int CW          = (c_max_ticks > 1) ? $clog2(c_max_ticks) : 1;
  localparam int IW          = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] c_dwell_last = CW'(DWELL_TICKS - 1);
  localparam logic [CW-1:0] c_blank_last = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IW-1:0] c_last_idx   = IW'(NUM_DIGITS - 1);

  state_t                  state_q,  state_d;
  logic [IW-1:0]           idx_q,    idx_d;
  logic [CW-1:0]           cnt_q,    cnt_d;
  logic [4*NUM_DIGITS-1:0] val_q,    val_d;
  logic [NUM_DIGITS-1:0]   dpsnap_q, dpsnap_d;
  logic                    lz_q,     lz_d;
  logic [NUM_DIGITS-1:0]   an_q,     an_d;
  logic [6:0]              seg_q,    seg_d;
  logic                    dp_q,     dp_d;

  logic                    w_advance;
  logic                    w_snapshot;
  logic [NUM_DIGITS-1:0]   w_supp;
  logic                    w_zero_run;
  logic [3:0]              w_digit;
  logic [6:0]              w_seg_hex;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    w_advance  = 1'b0;
    w_snapshot = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SHOW;
          idx_d      = '0;
          cnt_d      = '0;
          w_snapshot = 1'b1;
        end
        ST_SHOW: begin
          if (cnt_q == c_dwell_last) begin
            cnt_d = '0;
            if (BLANK_TICKS > 0) begin
              state_d = ST_BLANK;
            end else begin
              w_advance = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == c_blank_last) begin
            cnt_d     = '0;
            state_d   = ST_SHOW;
            w_advance = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase

      // A new frame starts on every wrap, so the snapshot never tears mid-frame
      if (w_advance) begin
        if (idx_q == c_last_idx) begin
          idx_d      = '0;
          w_snapshot = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  assign val_d    = w_snapshot ? value : val_q;
  assign dpsnap_d = w_snapshot ? dp_in : dpsnap_q;
  assign lz_d     = w_snapshot ? lz_en : lz_q;

  always_comb begin
    w_zero_run = 1'b1;
    w_supp     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (val_d[4*k +: 4] == 4'h0);
      w_supp[k]  = lz_d & (k != 0) & w_zero_run;
    end
  end

  // Outputs are decoded from next-state so they appear one cycle after the tick
  assign w_digit = val_d[{idx_d, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .hex_i (w_digit),
    .seg_o (w_seg_hex)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_d       = w_supp[idx_d] ? SEG_OFF : w_seg_hex;
      dp_d        = ~dpsnap_d[idx_d];
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      val_q    <= '0;
      dpsnap_q <= '0;
      lz_q     <= 1'b0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      dpsnap_q <= dpsnap_d;
      lz_q     <= lz_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
//==============================================================================
// tb_seg7_scan - directed and randomized checks of seg7_scan against a frame model. Rev 1.0
//==============================================================================
`default_nettype none

module tb_seg7_scan;

  localparam int ND    = 4;
  localparam int DW    = 2;
  localparam int BL    = 1;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = ND * SLOT;

  logic          clk;
  logic          rst_n;
  logic          tick;
  logic          en;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          lz_en;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;

  int            n_cmp;
  int            n_fail;
  int            t;
  logic [15:0]   m_val;
  logic [3:0]    m_dp;
  logic          m_lz;
  logic [6:0]    segtab [16];

  seg7_scan #(
    .NUM_DIGITS  (ND),
    .DWELL_TICKS (DW),
    .BLANK_TICKS (BL)
  ) dut (
    .in_clk (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .en     (en),
    .value  (value),
    .dp_in  (dp_in),
    .lz_en  (lz_en),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: t counts ticks since enable; position within the frame decides digit and phase
  task automatic check_model(input string tag);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic [3:0] dig;
    int         q;
    int         d;
    ea = 4'hF;
    es = 7'h7F;
    ed = 1'b1;
    if (t > 0) begin
      q = (t - 1) % FRAME;
      d = q / SLOT;
      if ((q % SLOT) < DW) begin
        ea    = 4'hF;
        ea[d] = 1'b0;
        dig   = 4'((m_val >> (4 * d)) & 16'hF);
        if (m_lz && d != 0 && (m_val >> (4 * d)) == 16'h0) es = 7'h7F;
        else es = segtab[dig];
        ed = ~m_dp[d];
      end
    end
    n_cmp++;
    assert (an === ea) else begin
      n_fail++;
      $error("FAIL %s an: observed %b expected %b (t=%0d)", tag, an, ea, t);
    end
    n_cmp++;
    assert (seg === es) else begin
      n_fail++;
      $error("FAIL %s seg: observed %h expected %h (t=%0d)", tag, seg, es, t);
    end
    n_cmp++;
    assert (dp === ed) else begin
      n_fail++;
      $error("FAIL %s dp: observed %b expected %b (t=%0d)", tag, dp, ed, t);
    end
  endtask

  task automatic chk_lit(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    n_cmp++;
    assert (an === ea && seg === es && dp === ed) else begin
      n_fail++;
      $error("FAIL %s: observed an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
             tag, an, seg, dp, ea, es, ed);
    end
  endtask

  task automatic step(input bit tk, input string tag);
    @(negedge clk);
    tick = tk;
    @(posedge clk);
    if (!en) begin
      t = 0;
    end else if (tk) begin
      t++;
      if ((t - 1) % FRAME == 0) begin
        m_val = value;
        m_dp  = dp_in;
        m_lz  = lz_en;
      end
    end
    #1;
    tick = 1'b0;
    check_model(tag);
  endtask

  task automatic restart();
    en = 1'b0;
    step(1'b0, "restart");
    en = 1'b1;
  endtask

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    n_cmp  = 0;
    n_fail = 0;
    t      = 0;
    m_val  = '0;
    m_dp   = '0;
    m_lz   = 1'b0;
    rst_n  = 1'b0;
    en     = 1'b0;
    tick   = 1'b0;
    value  = '0;
    dp_in  = '0;
    lz_en  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_lit("reset", 4'hF, 7'h7F, 1'b1);

    // Basic scan, tick every 10 cycles
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    value = 16'h1234;
    for (int i = 1; i <= 13; i++) begin
      repeat (9) step(1'b0, "gap");
      step(1'b1, "scan1234");
      if (i == 1)  chk_lit("tick1", 4'b1110, 7'h19, 1'b1);
      if (i == 3)  chk_lit("tick3", 4'hF, 7'h7F, 1'b1);
      if (i == 4)  chk_lit("tick4", 4'b1101, 7'h30, 1'b1);
      if (i == 13) chk_lit("wrap", 4'b1110, 7'h19, 1'b1);
    end

    // Leading-zero suppression on
    value = 16'h0070;
    lz_en = 1'b1;
    restart();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, "lz_on");
      if (i == 1)  chk_lit("lz_d0", 4'b1110, 7'h40, 1'b1);
      if (i == 4)  chk_lit("lz_d1", 4'b1101, 7'h78, 1'b1);
      if (i == 7)  chk_lit("lz_d2", 4'b1011, 7'h7F, 1'b1);
      if (i == 10) chk_lit("lz_d3", 4'b0111, 7'h7F, 1'b1);
    end

    // Leading-zero suppression off
    lz_en = 1'b0;
    restart();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, "lz_off");
      if (i == 7)  chk_lit("nolz_d2", 4'b1011, 7'h40, 1'b1);
      if (i == 10) chk_lit("nolz_d3", 4'b0111, 7'h40, 1'b1);
    end

    // Frame coherence: value changes while digit 1 is lit
    value = 16'h1111;
    restart();
    for (int i = 1; i <= 13; i++) begin
      if (i == 5) value = 16'h2222;
      step(1'b1, "coherent");
      if (i == 10) chk_lit("coh_d3", 4'b0111, 7'h79, 1'b1);
      if (i == 13) chk_lit("coh_next", 4'b1110, 7'h24, 1'b1);
    end

    // Decimal point on a suppressed digit
    value = 16'h0000;
    dp_in = 4'b0100;
    lz_en = 1'b1;
    restart();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, "dp");
      if (i == 7) chk_lit("dp_d2", 4'b1011, 7'h7F, 1'b0);
    end

    // Randomized traffic including back-to-back ticks and en drops
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in = 4'($urandom);
        lz_en = 1'($urandom);
      end
      if ($urandom_range(0, 59) == 0) begin
        en = 1'b0;
        step(1'($urandom), "rand_en0");
        en = 1'b1;
      end
      step($urandom_range(0, 2) != 0, "rand");
    end

    // en dropped mid-SHOW without a tick
    value = 16'h1234;
    dp_in = 4'b0000;
    lz_en = 1'b0;
    restart();
    step(1'b1, "en_pre");
    step(1'b1, "en_pre");
    en = 1'b0;
    step(1'b0, "en_drop");
    chk_lit("en_drop", 4'hF, 7'h7F, 1'b1);
    en = 1'b1;
    step(1'b0, "en_back");
    step(1'b1, "en_tick");
    chk_lit("en_tick", 4'b1110, 7'h19, 1'b1);

    // Asynchronous reset between edges during SHOW
    step(1'b1, "rst_pre");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_lit("async_rst", 4'hF, 7'h7F, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    repeat (5) step(1'b0, "post_rst");
    step(1'b1, "post_rst_tick");
    chk_lit("post_rst_tick", 4'b1110, 7'h19, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
